// File: rtl/ram_arbiter.sv
// Two-port data-RAM arbiter: loader (p0) and load/store (p1), bounded p0/p1 lock.
// Optional round-robin tie break when RAM_ARB_ROUND_ROBIN_EN is defined.
module ram_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                p0_valid,
  input  logic                p0_wen,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [DATA_W-1:0]   p0_wdata,
  input  logic [DATA_W/8-1:0] p0_wstrb,
  input  logic                p0_lock,
  output logic                p0_ready,
  output logic                p0_rsp_valid,
  output logic [DATA_W-1:0]   p0_rsp_rdata,
  input  logic                p1_valid,
  input  logic                p1_wen,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [DATA_W-1:0]   p1_wdata,
  input  logic [DATA_W/8-1:0] p1_wstrb,
  input  logic                p1_lock,
  output logic                p1_ready,
  output logic                p1_rsp_valid,
  output logic [DATA_W-1:0]   p1_rsp_rdata,
  output logic                ram_wen,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_wstrb,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int SW = DATA_W / 8;
  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  owner_t              r_owner;
  logic                r_last_grant;
  logic                r_force;
  logic [CW-1:0]       r_lock_cnt;
  logic                r_rsp_v0;
  logic                r_rsp_v1;
  logic [DATA_W-1:0]   r_rsp_d0;
  logic [DATA_W-1:0]   r_rsp_d1;

  logic                w_g0;
  logic                w_g1;
  logic                w_gnt;
  logic                w_tie_p1;
  logic                w_sel_wen;
  logic                w_sel_lock;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [SW-1:0]       w_sel_wstrb;

  // r_force marks the cycle right after a forced release: non-owner wins ties
  always_comb begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
    w_tie_p1 = ~r_last_grant;
`else
    w_tie_p1 = r_force & ~r_last_grant;
`endif
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (!reset) begin
      unique case (r_owner)
        OWN_P0: w_g0 = p0_valid;
        OWN_P1: w_g1 = p1_valid;
        default: begin
          w_g1 = p1_valid & (~p0_valid | w_tie_p1);
          w_g0 = p0_valid & ~w_g1;
        end
      endcase
    end
  end

  assign w_gnt       = w_g0 | w_g1;
  assign w_sel_wen   = w_g1 ? p1_wen   : p0_wen;
  assign w_sel_lock  = w_g1 ? p1_lock  : p0_lock;
  assign w_sel_addr  = w_g1 ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_g1 ? p1_wdata : p0_wdata;
  assign w_sel_wstrb = w_g1 ? p1_wstrb : p0_wstrb;

  assign p0_ready  = w_g0;
  assign p1_ready  = w_g1;
  assign ram_wen   = w_gnt & w_sel_wen;
  assign ram_addr  = w_gnt ? w_sel_addr : '0;
  assign ram_wdata = w_gnt ? w_sel_wdata : '0;
  assign ram_wstrb = ram_wen ? w_sel_wstrb : '0;

  assign p0_rsp_valid = r_rsp_v0;
  assign p0_rsp_rdata = r_rsp_d0;
  assign p1_rsp_valid = r_rsp_v1;
  assign p1_rsp_rdata = r_rsp_d1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner      <= OWN_NONE;
      r_last_grant <= 1'b1;
      r_force      <= 1'b0;
      r_lock_cnt   <= '0;
      r_rsp_v0     <= 1'b0;
      r_rsp_v1     <= 1'b0;
      r_rsp_d0     <= '0;
      r_rsp_d1     <= '0;
    end else begin
      r_force  <= 1'b0;
      r_rsp_v0 <= w_g0;
      r_rsp_v1 <= w_g1;
      r_rsp_d0 <= (w_g0 & ~p0_wen) ? ram_rdata : '0;
      r_rsp_d1 <= (w_g1 & ~p1_wen) ? ram_rdata : '0;
      if (w_gnt) begin
        r_last_grant <= w_g1;
        if (!w_sel_lock) begin
          r_owner    <= OWN_NONE;
          r_lock_cnt <= '0;
        end else if (r_lock_cnt == CW'(MAX_LOCK - 1)) begin
          // lock budget exhausted on this beat: release at this edge
          r_owner    <= OWN_NONE;
          r_lock_cnt <= '0;
          r_force    <= 1'b1;
        end else begin
          r_owner    <= w_g1 ? OWN_P1 : OWN_P0;
          r_lock_cnt <= r_lock_cnt + 1'b1;
        end
      end
    end
  end

endmodule
